// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches over a valid/ready request plus response-valid bus, and presents decoded fields.
// Optional misaligned-redirect fault: define FETCH_MISALIGN_CHECK_EN.
module instr_fetch_unit #(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            pc_src,
  input  logic [XLEN-1:0] pc_target,
  input  logic            instr_ready,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_plus4,
  output logic [6:0]      opcode,
  output logic [2:0]      funct3,
  output logic [6:0]      funct7,
  output logic [4:0]      rd,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic            fetch_fault
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HOLD
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    ST_FAULT
`endif
  } state_t;

  state_t          r_state;
  state_t          w_state_next;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pc_next;
  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] w_instr_next;
  logic [XLEN-1:0] w_pc_plus4;

  assign w_pc_plus4 = r_pc + XLEN'(32'd4);

  // State, PC and instruction register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pc    <= RESET_PC;
      r_instr <= NOP_INSTR;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      r_instr <= w_instr_next;
    end
  end

  // Next-state logic; responses outside WAIT and redirects outside an accepted HOLD are ignored
  always_comb begin
    w_state_next = r_state;
    w_pc_next    = r_pc;
    w_instr_next = r_instr;
    case (r_state)
      ST_IDLE: w_state_next = ST_REQ;
      ST_REQ: begin
        if (imem_req_ready) w_state_next = ST_WAIT;
      end
      ST_WAIT: begin
        if (imem_rsp_valid) begin
          w_instr_next = imem_rdata;
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (instr_ready) begin
`ifdef FETCH_MISALIGN_CHECK_EN
          if (pc_src && (pc_target[1:0] != 2'b00)) begin
            w_state_next = ST_FAULT;
          end else begin
            w_state_next = ST_REQ;
            w_pc_next    = pc_src ? pc_target : w_pc_plus4;
          end
`else
          w_state_next = ST_REQ;
          w_pc_next    = pc_src ? pc_target : w_pc_plus4;
`endif
        end
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      ST_FAULT: w_state_next = ST_FAULT;
`endif
      default: w_state_next = ST_IDLE;
    endcase
  end

  assign imem_req_valid = (r_state == ST_REQ);
  assign imem_addr      = r_pc;
  assign instr_valid    = (r_state == ST_HOLD);
  assign instr          = r_instr;
  assign pc             = r_pc;
  assign pc_plus4       = w_pc_plus4;

`ifdef FETCH_MISALIGN_CHECK_EN
  assign fetch_fault = (r_state == ST_FAULT);
`else
  assign fetch_fault = 1'b0;
`endif

  assign opcode = r_instr[6:0];
  assign rd     = r_instr[11:7];
  assign funct3 = r_instr[14:12];
  assign rs1    = r_instr[19:15];
  assign rs2    = r_instr[24:20];
  assign funct7 = r_instr[31:25];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed self-checking bench for instr_fetch_unit (FETCH_MISALIGN_CHECK_EN selects the fault expectations).
module tb_instr_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rdata;
  logic        pc_src;
  logic [31:0] pc_target;
  logic        instr_ready;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic        fetch_fault;

  int n_vec;
  int n_fail;

  instr_fetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rdata     (imem_rdata),
    .pc_src         (pc_src),
    .pc_target      (pc_target),
    .instr_ready    (instr_ready),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .pc             (pc),
    .pc_plus4       (pc_plus4),
    .opcode         (opcode),
    .funct3         (funct3),
    .funct7         (funct7),
    .rd             (rd),
    .rs1            (rs1),
    .rs2            (rs2),
    .fetch_fault    (fetch_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // From REQ: accept immediately, respond the following cycle; ends in HOLD
  task automatic fetch(input logic [31:0] data);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rdata     = data;
    step();
    imem_rsp_valid = 1'b0;
  endtask

  // From HOLD: downstream consumes the instruction with the given redirect
  task automatic advance(input logic src, input logic [31:0] target);
    instr_ready = 1'b1;
    pc_src      = src;
    pc_target   = target;
    step();
    instr_ready = 1'b0;
    pc_src      = 1'b0;
    pc_target   = 32'h0;
  endtask

  logic [31:0] w_dec;

  initial begin
    n_vec = 0;
    n_fail = 0;
    rst_n = 1'b0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rdata = 32'h0;
    pc_src = 1'b0;
    pc_target = 32'h0;
    instr_ready = 1'b0;
    step();
    step();

    check("rst_req_valid", 32'(imem_req_valid), 32'h0);
    check("rst_instr_valid", 32'(instr_valid), 32'h0);
    check("rst_instr", instr, 32'h0000_0013);
    check("rst_opcode", 32'(opcode), 32'h13);
    check("rst_pc", pc, 32'h0);
    check("rst_fault", 32'(fetch_fault), 32'h0);

    // Zero-wait fetch at address 0
    rst_n = 1'b1;
    imem_req_ready = 1'b1;
    step();
    check("t1_req_valid", 32'(imem_req_valid), 32'h1);
    check("t1_addr", imem_addr, 32'h0);
    step();
    check("t1_wait_req_valid", 32'(imem_req_valid), 32'h0);
    check("t1_wait_instr_valid", 32'(instr_valid), 32'h0);
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rdata = 32'h0000_0033;
    step();
    imem_rsp_valid = 1'b0;
    check("t1_instr_valid", 32'(instr_valid), 32'h1);
    check("t1_opcode", 32'(opcode), 32'h33);
    check("t1_pc", pc, 32'h0);
    check("t1_pc_plus4", pc_plus4, 32'h4);
    advance(1'b0, 32'h0);
    check("t1_next_addr", imem_addr, 32'h4);
    check("t1_next_req_valid", 32'(imem_req_valid), 32'h1);
    check("t1_next_instr_valid", 32'(instr_valid), 32'h0);

    // Slow memory at address 8: ready low 3 cycles, response 2 cycles after accept
    fetch(32'h0000_0013);
    advance(1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t2_hold_req_valid", 32'(imem_req_valid), 32'h1);
      check("t2_hold_addr", imem_addr, 32'h8);
    end
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      check("t2_wait_instr_valid", 32'(instr_valid), 32'h0);
    end
    imem_rsp_valid = 1'b1;
    imem_rdata = 32'h0000_0013;
    step();
    imem_rsp_valid = 1'b0;
    check("t2_instr_valid_rise", 32'(instr_valid), 32'h1);
    check("t2_pc", pc, 32'h8);

    // Decode of a constructed instruction at pc 0x10
    advance(1'b0, 32'h0);
    fetch(32'h0000_0013);
    advance(1'b0, 32'h0);
    w_dec = {7'h5A, 5'd7, 5'd9, 3'd5, 5'd11, 7'h33};
    fetch(w_dec);
    check("t3_pc", pc, 32'h10);
    check("t3_funct7", 32'(funct7), 32'h5A);
    check("t3_rs2", 32'(rs2), 32'd7);
    check("t3_rs1", 32'(rs1), 32'd9);
    check("t3_funct3", 32'(funct3), 32'd5);
    check("t3_rd", 32'(rd), 32'd11);
    check("t3_opcode", 32'(opcode), 32'h33);

    // Redirect inputs without instr_ready have no effect
    pc_src = 1'b1;
    pc_target = 32'h80;
    step();
    pc_src = 1'b0;
    step();
    check("t3_noready_valid", 32'(instr_valid), 32'h1);
    check("t3_noready_pc", pc, 32'h10);
    advance(1'b1, 32'h40);
    check("t3_redirect_addr", imem_addr, 32'h40);
    fetch(32'h0000_0013);
    advance(1'b1, 32'h10);
    check("t3_back_addr", imem_addr, 32'h10);
    fetch(32'h0000_0013);
    advance(1'b0, 32'h40);
    check("t3_seq_addr", imem_addr, 32'h14);

    // PC wrap at the top of the address space
    fetch(32'h0000_0013);
    advance(1'b1, 32'hFFFF_FFFC);
    check("t4_top_addr", imem_addr, 32'hFFFF_FFFC);
    fetch(32'h0000_0013);
    check("t4_pc_plus4_wrap", pc_plus4, 32'h0);
    advance(1'b0, 32'h0);
    check("t4_wrap_addr", imem_addr, 32'h0);

    // Reset in WAIT, then a stale response in REQ must be ignored
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t5_async_req_valid", 32'(imem_req_valid), 32'h0);
    check("t5_async_pc", pc, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    check("t5_req_valid", 32'(imem_req_valid), 32'h1);
    imem_rsp_valid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_rsp_valid = 1'b0;
    check("t5_stale_req_valid", 32'(imem_req_valid), 32'h1);
    check("t5_stale_instr", instr, 32'h0000_0013);
    check("t5_stale_instr_valid", 32'(instr_valid), 32'h0);
    check("t5_pc", pc, 32'h0);
    imem_req_ready = 1'b1;
    step();
    imem_req_ready = 1'b0;
    check("t5_wait_instr", instr, 32'h0000_0013);
    imem_rsp_valid = 1'b1;
    imem_rdata = 32'h0000_0033;
    step();
    imem_rsp_valid = 1'b0;
    check("t5_new_instr", instr, 32'h0000_0033);

    // Misaligned redirect
    advance(1'b1, 32'h42);
`ifdef FETCH_MISALIGN_CHECK_EN
    imem_req_ready = 1'b1;
    check("t6_fault", 32'(fetch_fault), 32'h1);
    check("t6_instr_valid", 32'(instr_valid), 32'h0);
    check("t6_pc", pc, 32'h0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t6_no_req", 32'(imem_req_valid), 32'h0);
      check("t6_fault_sticky", 32'(fetch_fault), 32'h1);
    end
    imem_req_ready = 1'b0;
`else
    check("t6_addr", imem_addr, 32'h42);
    check("t6_fault", 32'(fetch_fault), 32'h0);
    check("t6_req_valid", 32'(imem_req_valid), 32'h1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage directly upstream of control_unit.
- Holds the PC, fetches instructions from instruction memory over a valid/ready request plus response-valid interface, and latches each instruction.
- Presents decoded fields (opcode, funct3, funct7, rs1, rs2, rd) to control_unit and the datapath.
- Advances the PC by +4, or to a redirect target when the executing instruction's PCSrc is asserted.

Parameters:
- XLEN, 32, width of PC and instruction word.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, instruction register reset value (addi x0,x0,0).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts request.
- imem_addr  out  XLEN  fetch address (= pc).
- imem_rsp_valid  in  1  response data valid.
- imem_rdata  in  XLEN  fetched instruction.
- pc_src  in  1  redirect select (control_unit PCSrc, covers branches and Jump).
- pc_target  in  XLEN  redirect address from datapath.
- instr_ready  in  1  downstream has executed the presented instruction.
- instr_valid  out  1  instr and decoded fields are valid.
- instr  out  XLEN  latched instruction.
- pc  out  XLEN  address of the presented instruction.
- pc_plus4  out  XLEN  pc+4, for JAL/JALR writeback.
- opcode  out  7  instr[6:0].
- funct3  out  3  instr[14:12].
- funct7  out  7  instr[31:25].
- rd  out  5  instr[11:7].
- rs1  out  5  instr[19:15].
- rs2  out  5  instr[24:20].
- fetch_fault  out  1  misaligned-target fault (optional feature only; tied 0 otherwise).

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, pc=RESET_PC, instr=NOP_INSTR.
  - instr_valid=0, imem_req_valid=0, fetch_fault=0.
  - Decoded fields follow instr, so opcode=7'b0010011 during reset.
- States:
  - IDLE → REQ unconditionally on the first clock after reset release.
  - REQ: imem_req_valid=1, imem_addr=pc. On imem_req_ready=1 → WAIT.
  - WAIT: imem_req_valid=0. On imem_rsp_valid=1, latch instr←imem_rdata and go to HOLD.
  - HOLD: instr_valid=1; instr and pc stable. On instr_ready=1:
    - pc ← pc_src ? pc_target : pc+4
    - instr_valid=0 next cycle
    - → REQ
- Latency:
  - Request accept to instr_valid = response delay + 1 cycle.
  - Zero-wait memory (ready=1, rsp the cycle after accept) gives one instruction every 3 cycles.
- imem_rsp_valid is ignored outside WAIT. This covers stale responses after a mid-transaction reset and responses coincident with request accept.
- pc_src and pc_target are sampled only in the HOLD cycle where instr_ready=1; ignored otherwise.
- PC arithmetic is modulo 2^XLEN: pc=32'hFFFF_FFFC advances to 32'h0000_0000.
- pc_plus4 is combinational pc+4 with the same wrap.
- imem_addr and imem_req_valid stay stable while in REQ with ready low; no retraction.
- Decoded fields are pure slices of instr and are valid only while instr_valid=1.

Optional Feature:
- Macro FETCH_MISALIGN_CHECK_EN.
- Defined:
  - In HOLD with instr_ready=1 and pc_src=1, if pc_target[1:0]!=2'b00, go to FAULT instead of REQ; pc is not updated.
  - In FAULT: fetch_fault=1 and imem_req_valid=0; instr_valid returns to 0.
  - FAULT exits only on reset.
- Undefined:
  - No FAULT state; fetch_fault tied 0.
  - pc_target is loaded as-is, low bits included.

Test Plan:
- Reset, then zero-wait memory returning 32'h0000_0033 at addr 0 → imem_addr=0 in cycle 1 after release; instr_valid=1 with opcode=0110011, pc=0, pc_plus4=4; after instr_ready, next imem_addr=4.
- Memory holds ready=0 for 3 cycles, then returns rsp after 2 further cycles → imem_req_valid and imem_addr=8 stable throughout; instr_valid rises exactly 1 cycle after rsp_valid.
- HOLD with pc=0x10, instr_ready=1, pc_src=1, pc_target=0x40 → next imem_addr=0x40. Same with pc_src=0 → 0x14. Toggling pc_src while instr_ready=0 → no effect.
- pc=32'hFFFF_FFFC, sequential advance → next imem_addr=0, pc_plus4 reads 0 before the advance.
- Assert rst_n low during WAIT, release, inject stale imem_rsp_valid in REQ → ignored; pc=RESET_PC; instr=0x0000_0013 until the new response.
- With FETCH_MISALIGN_CHECK_EN: redirect to 0x42 → fetch_fault=1, no further imem_req_valid, pc unchanged. Without the macro: imem_addr=0x42, fetch_fault=0.
